imm_extender_pipe: RTL and testbench
====================================

Name: imm_extender_pipe

Overview:
Parametrised, registered successor to the fixed 4-to-16 sign extender. Accepts an immediate field plus a mode, then produces an OUT_W-bit operand. Supported modes are sign-extend, zero-extend, sign-extend-and-shift, and upper placement. The block sits between decode and the ALU operand mux, uses a valid/ready handshake, and has a 2-entry skid buffer so it can absorb ALU-side stalls without combinational ready paths.

Parameters:
IN_W, 4, width of immediate field (>=1)
OUT_W, 16, width of extended operand (>= IN_W + 2**SH_W - 1)
SH_W, 2, width of shift-amount input; shift range 0..2**SH_W-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat; driven directly from a register
in_imm  input  IN_W  raw immediate field
in_mode  input  2  00 sign, 01 zero, 10 sign+shift, 11 upper
in_shamt  input  SH_W  left-shift amount; used in mode 10 only
in_prefix  input  1  prefix beat marker; used only with IMM_PREFIX_EN
out_valid  output  1  extended operand valid
out_ready  input  1  downstream accepts
out_imm  output  OUT_W  extended operand
out_neg  output  1  equals out_imm[OUT_W-1]
out_trunc  output  1  mode 10 result not representable in OUT_W bits

Behaviour:
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Mode 00: out = sign-extend(in_imm) to OUT_W bits.
- Mode 01: out = zero-extend(in_imm) to OUT_W bits.
- Mode 10: out = sign-extend(in_imm) shifted left by in_shamt, with zeros filled at the LSBs. out_trunc = 1 when the bits discarded above OUT_W are not all equal to the resulting out_imm[OUT_W-1]. With the OUT_W constraint met, out_trunc is 0. The flag must still be computed generically.
- Mode 11: out = {in_imm, (OUT_W-IN_W) zeros}.
- out_trunc is 0 in all modes except 10.
- Result is computed from the accepted beat and registered. Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N when the buffer was empty.
- Storage: a main output register (M) and a skid register (S).
  - States: EMPTY (M invalid), ONE (M valid, S invalid), FULL (both valid).
  - EMPTY: accept -> ONE.
  - ONE: accept with no drain -> FULL (new beat goes to S). Drain with no accept -> EMPTY. Accept and drain in the same cycle -> ONE (new beat goes to M).
  - FULL: drain -> ONE (S moves to M). No accept is possible in FULL.
- in_ready = registered (state != FULL). It is deasserted in the cycle after the buffer fills, never combinationally from out_ready.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- out_* hold stable while out_valid && !out_ready.
- Reset, including mid-operation: state = EMPTY, out_valid = 0, in_ready = 1, out_imm = 0, out_neg = 0, out_trunc = 0, S cleared. Any pending prefix is cleared.

Optional Feature:
Macro IMM_PREFIX_EN.
- Defined: an accepted beat with in_prefix = 1 is not forwarded to the output.
  - It loads in_imm into a prefix register and sets pfx_valid.
  - The next accepted beat with in_prefix = 0 is extended using the 2*IN_W-bit value {pfx, in_imm} in place of in_imm, under the same mode rules. That beat clears pfx_valid.
  - A second prefix before a non-prefix beat overwrites the first.
  - A prefix beat is always accepted while in_ready = 1 and does not change the buffer state.
  - Requires OUT_W >= 2*IN_W + 2**SH_W - 1.
- Undefined: in_prefix is ignored and every beat is treated as a normal beat. No prefix register is synthesised.

Test Plan:
1. Defaults, out_ready = 1. in_imm = 4'hA, mode 00 -> one cycle later out_imm = 16'hFFFA, out_neg = 1. Mode 01 -> 16'h000A, out_neg = 0.
2. Mode 10, in_imm = 4'hE, shamt = 3 -> 16'hFFF0, out_trunc = 0. Mode 11, in_imm = 4'h5 -> 16'h5000.
3. Backpressure: out_ready = 0, send 0x1, 0x2, 0x3 on consecutive cycles -> in_ready drops after the second beat is accepted and the third beat is held upstream. Raise out_ready -> outputs 0x0001, 0x0002, 0x0003 in order, with no loss or duplication.
4. Simultaneous accept and drain in ONE, streaming continuously with out_ready = 1 -> throughput of 1 beat per cycle, in_ready stays 1, state never reaches FULL.
5. Reset asserted asynchronously while FULL -> out_valid = 0, in_ready = 1, and out_imm = 0 immediately, without waiting for a clock edge. The first beat after reset is delivered with 1-cycle latency.
6. IMM_PREFIX_EN defined, IN_W = 4, OUT_W = 16: prefix beat 4'h8, then a mode 00 beat with 4'h3 -> a single output 16'hFF83. Without the macro, the same stimulus -> two outputs, 16'hFFF8 then 16'h0003.

Source files
------------

// File: rtl/imm_extender_pipe.sv
// rtl/imm_extender_pipe.sv - registered immediate extender with 2-entry skid buffer; optional prefix beats under IMM_PREFIX_EN
module imm_extender_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int SH_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [SH_W-1:0]  in_shamt,
  input  logic             in_prefix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_neg,
  output logic             out_trunc
);

  localparam int SHMAX = (1 << SH_W) - 1;
`ifdef IMM_PREFIX_EN
  localparam int EW = 2 * IN_W;
`else
  localparam int EW = IN_W;
`endif
  // Wide enough that the shifted sign-extended source never loses bits before the trunc test.
  localparam int XW = OUT_W + EW + SHMAX;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state, state_n;
  logic             in_ready_q;
  logic [OUT_W-1:0] m_imm, s_imm, res_imm;
  logic             m_trunc, s_trunc, res_trunc;
  logic             acc, acc_data, drain;
  logic             load_m, load_s, move_s;
  logic [EW-1:0]    sx_src, zx_src;
  logic [OUT_W-1:0] up_val;
  logic [XW-1:0]    sx_val, sh_val;

  assign acc       = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_imm   = m_imm;
  assign out_neg   = m_imm[OUT_W-1];
  assign out_trunc = m_trunc;

`ifdef IMM_PREFIX_EN
  logic [IN_W-1:0] pfx;
  logic            pfx_valid;

  // A prefix beat only feeds the buffer indirectly, so it never counts as a data beat.
  assign acc_data = acc && !in_prefix;

  // Prefix register: loaded by a prefix beat, consumed by the next data beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pfx       <= '0;
      pfx_valid <= 1'b0;
    end else if (acc && in_prefix) begin
      pfx       <= in_imm;
      pfx_valid <= 1'b1;
    end else if (acc_data) begin
      pfx_valid <= 1'b0;
    end
  end
`else
  logic unused_prefix;
  assign unused_prefix = in_prefix;
  assign acc_data      = acc;
`endif

  // Extend the incoming beat according to its mode.
  always_comb begin
    sx_src  = '0;
    zx_src  = '0;
    up_val  = '0;
`ifdef IMM_PREFIX_EN
    if (pfx_valid) begin
      sx_src                 = {pfx, in_imm};
      zx_src                 = {pfx, in_imm};
      up_val[OUT_W-1 -: EW]  = {pfx, in_imm};
    end else begin
      sx_src                 = {EW{in_imm[IN_W-1]}};
      sx_src[IN_W-1:0]       = in_imm;
      zx_src[IN_W-1:0]       = in_imm;
      up_val[OUT_W-1 -: IN_W] = in_imm;
    end
`else
    sx_src                  = in_imm;
    zx_src                  = in_imm;
    up_val[OUT_W-1 -: IN_W] = in_imm;
`endif
    sx_val         = {XW{sx_src[EW-1]}};
    sx_val[EW-1:0] = sx_src;
    sh_val         = sx_val << in_shamt;
    res_imm        = '0;
    res_trunc      = 1'b0;
    case (in_mode)
      2'b00: res_imm = sx_val[OUT_W-1:0];
      2'b01: res_imm[EW-1:0] = zx_src;
      2'b10: begin
        res_imm   = sh_val[OUT_W-1:0];
        res_trunc = (sh_val[XW-1:OUT_W] != {(XW-OUT_W){sh_val[OUT_W-1]}});
      end
      default: res_imm = up_val;
    endcase
  end

  // Buffer occupancy register and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != FULL);
    end
  end

  // Next occupancy and which register captures the new or skid beat.
  always_comb begin
    state_n = state;
    load_m  = 1'b0;
    load_s  = 1'b0;
    move_s  = 1'b0;
    case (state)
      EMPTY: begin
        if (acc_data) begin
          state_n = ONE;
          load_m  = 1'b1;
        end
      end
      ONE: begin
        if (acc_data && drain) begin
          load_m = 1'b1;
        end else if (acc_data) begin
          state_n = FULL;
          load_s  = 1'b1;
        end else if (drain) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_n = ONE;
          move_s  = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // Main and skid data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_imm   <= '0;
      m_trunc <= 1'b0;
      s_imm   <= '0;
      s_trunc <= 1'b0;
    end else begin
      if (move_s) begin
        m_imm   <= s_imm;
        m_trunc <= s_trunc;
      end else if (load_m) begin
        m_imm   <= res_imm;
        m_trunc <= res_trunc;
      end
      if (load_s) begin
        s_imm   <= res_imm;
        s_trunc <= res_trunc;
      end
    end
  end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// tb/tb_imm_extender_pipe.sv - directed and random checks of imm_extender_pipe against a behavioural model
module tb_imm_extender_pipe;
  localparam int IN_W  = 4;
  localparam int OUT_W = 16;
  localparam int SH_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [SH_W-1:0]  in_shamt;
  logic             in_prefix;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic             out_neg;
  logic             out_trunc;

  int total = 0;
  int bad   = 0;
  bit last_acc;
  logic [16:0] expq[$];
  logic [3:0] m_pfx;
  bit         m_pfx_v;

  imm_extender_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .in_shamt(in_shamt), .in_prefix(in_prefix),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_neg(out_neg), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  // value of width w interpreted per mode rules; returns {trunc, out}
  function automatic logic [16:0] model(input logic [7:0] val, input int w,
                                        input logic [1:0] mode, input int sh);
    longint s, full;
    logic [15:0] o;
    logic t;
    t = 1'b0;
    s = (longint'(val) >= (longint'(1) << (w - 1))) ? longint'(val) - (longint'(1) << w) : longint'(val);
    case (mode)
      2'd0: o = 16'(s);
      2'd1: o = 16'(val);
      2'd2: begin
        full = s * (longint'(1) << sh);
        o    = 16'(full);
        t    = (full < -32768) || (full > 32767);
      end
      default: o = 16'(longint'(val) << (16 - w));
    endcase
    return {t, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, score handshakes just before the rising edge.
  task automatic cyc(input bit v, input logic [3:0] imm, input logic [1:0] mode,
                     input logic [1:0] sh, input bit pfx, input bit ordy);
    logic [16:0] e;
    in_valid = v; in_imm = imm; in_mode = mode; in_shamt = sh; in_prefix = pfx; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      chk("queue_nonempty_on_drain", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_imm", out_imm, e[15:0]);
        chk("out_trunc", out_trunc, e[16]);
        chk("out_neg", out_neg, e[15]);
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
`ifdef IMM_PREFIX_EN
      if (pfx) begin
        m_pfx = imm; m_pfx_v = 1'b1;
      end else begin
        if (m_pfx_v) expq.push_back(model({m_pfx, imm}, 8, mode, int'(sh)));
        else         expq.push_back(model({4'h0, imm}, 4, mode, int'(sh)));
        m_pfx_v = 1'b0;
      end
`else
      expq.push_back(model({4'h0, imm}, 4, mode, int'(sh)));
`endif
    end
    @(negedge clk);
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < 20 && expq.size() > 0; i++) cyc(1'b0, 4'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    chk({tag, "_queue_empty"}, 32'(expq.size()), 32'd0);
    chk({tag, "_valid_low"}, out_valid, 1'b0);
  endtask

  initial begin
    bit sent;
    int nacc;
    rst = 1'b1; in_valid = 0; in_imm = 0; in_mode = 0; in_shamt = 0; in_prefix = 0; out_ready = 0;
    m_pfx = 0; m_pfx_v = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_imm", out_imm, 16'h0000);
    chk("rst_trunc", out_trunc, 1'b0);
    rst = 1'b0;

    // modes 00/01/10/11 with 1-cycle latency
    cyc(1, 4'hA, 2'd0, 2'd0, 0, 1);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_sign", out_imm, 16'hFFFA);
    chk("t1_neg", out_neg, 1'b1);
    cyc(1, 4'hA, 2'd1, 2'd0, 0, 1);
    chk("t1_zero", out_imm, 16'h000A);
    chk("t1_neg0", out_neg, 1'b0);
    cyc(1, 4'hE, 2'd2, 2'd3, 0, 1);
    chk("t2_shift", out_imm, 16'hFFF0);
    chk("t2_trunc", out_trunc, 1'b0);
    cyc(1, 4'h5, 2'd3, 2'd0, 0, 1);
    chk("t2_upper", out_imm, 16'h5000);
    drain_all("t2");

    // backpressure fills the skid buffer
    cyc(1, 4'h1, 2'd0, 2'd0, 0, 0);
    chk("t3_ready_one", in_ready, 1'b1);
    cyc(1, 4'h2, 2'd0, 2'd0, 0, 0);
    chk("t3_ready_full", in_ready, 1'b0);
    cyc(1, 4'h3, 2'd0, 2'd0, 0, 0);
    chk("t3_third_held", 32'(last_acc), 32'd0);
    cyc(1, 4'h3, 2'd0, 2'd0, 0, 0);
    chk("t3_stable", out_imm, 16'h0001);
    sent = 0;
    for (int i = 0; i < 10 && !sent; i++) begin
      cyc(1, 4'h3, 2'd0, 2'd0, 0, 1);
      sent = last_acc;
    end
    chk("t3_third_sent", 32'(sent), 32'd1);
    drain_all("t3");

    // continuous streaming
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 4'($urandom), 2'd0, 2'd0, 0, 1);
      if (last_acc) nacc++;
      chk("t4_ready", in_ready, 1'b1);
    end
    chk("t4_accepts", nacc, 20);
    drain_all("t4");

    // async reset while FULL
    cyc(1, 4'h7, 2'd0, 2'd0, 0, 0);
    cyc(1, 4'h9, 2'd0, 2'd0, 0, 0);
    chk("t5_full", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", out_valid, 1'b0);
    chk("t5_async_ready", in_ready, 1'b1);
    chk("t5_async_imm", out_imm, 16'h0000);
    chk("t5_async_neg", out_neg, 1'b0);
    expq.delete();
    m_pfx_v = 0;
    in_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 4'h6, 2'd0, 2'd0, 0, 1);
    chk("t5_first_valid", out_valid, 1'b1);
    chk("t5_first_imm", out_imm, 16'h0006);
    drain_all("t5");

    // prefix beat followed by data beat
    cyc(1, 4'h8, 2'd0, 2'd0, 1, 1);
    cyc(1, 4'h3, 2'd0, 2'd0, 0, 1);
`ifdef IMM_PREFIX_EN
    chk("t6_prefixed", out_imm, 16'hFF83);
`else
    chk("t6_plain", out_imm, 16'h0003);
`endif
    drain_all("t6");

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    drain_all("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
